logical_rs_sched: RTL and testbench

- Reservation-station scheduler feeding the single-cycle logical/shift FU in the OOO backend.
- Buffers up to RS_DEPTH dispatched logical ops and captures operand values from the CDB (wakeup).
- Issues at most one oldest-ready op per cycle to the FU as a registered issue packet.

---
 rtl/logical_rs_sched_pkg.sv | 31 +++
 rtl/logical_rs_sched_if.sv | 64 ++++++
 rtl/logical_rs_sched_age_matrix_select.sv | 61 ++++++
 rtl/logical_rs_sched.sv | 203 ++++++++++++++++++++
 tb/tb_logical_rs_sched.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logical_rs_sched_pkg.sv
// Shared types and constants for the logical/shift reservation station.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   logical_type_e : FU function-select codes
//   OPC_LOGICAL    : pass-through major opcode carried with logical ops
//   op_ctrl_t      : control portion of the issue packet
//   tag_w()        : ROB tag width derived from the ROB size
package logical_pkg;

    typedef enum logic [2:0] {
        LT_SLL = 3'b001,
        LT_XOR = 3'b100,
        LT_SR  = 3'b101,
        LT_OR  = 3'b110,
        LT_AND = 3'b111
    } logical_type_e;

    localparam logic [4:0] OPC_LOGICAL = 5'b01101;

    // Function select, opcode and shift flag travel together from dispatch to issue.
    typedef struct packed {
        logic [2:0] logical_type;
        logic [4:0] opcode;
        logic       additional_info;
    } op_ctrl_t;

    function automatic int tag_w(input int rob_size);
        return $clog2(rob_size);
    endfunction

endpackage

// File: rtl/logical_rs_sched_if.sv
// Dispatch / CDB / issue bundle between the rename stage, CDB and the logical scheduler.
// Latency: n/a (wires only).
// Backpressure: disp_ready gates dispatch; issue side has no backpressure.
//   master : dispatch + CDB + flush driver, consumes issue packet and occupancy
//   slave  : the scheduler
interface logical_rs_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int OCC_W = 3
);
    logic             flush;

    logic             disp_valid;
    logic             disp_ready;
    logic [TAG_W-1:0] disp_rob_entry;
    logic [2:0]       disp_logical_type;
    logic [4:0]       disp_opcode;
    logic             disp_additional_info;
    logic             disp_rs1_rdy;
    logic             disp_rs2_rdy;
    logic [TAG_W-1:0] disp_rs1_tag;
    logic [TAG_W-1:0] disp_rs2_tag;
    logic [XLEN-1:0]  disp_rs1_val;
    logic [XLEN-1:0]  disp_rs2_val;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;

    logic             iss_valid;
    logic [TAG_W-1:0] iss_rob_entry;
    logic [2:0]       iss_logical_type;
    logic [4:0]       iss_opcode;
    logic             iss_additional_info;
    logic [XLEN-1:0]  iss_rs1;
    logic [XLEN-1:0]  iss_rs2;

    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush,
        output disp_valid, disp_rob_entry, disp_logical_type, disp_opcode,
               disp_additional_info, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_val, disp_rs2_val,
        output cdb_valid, cdb_tag, cdb_value,
        input  disp_ready,
        input  iss_valid, iss_rob_entry, iss_logical_type, iss_opcode,
               iss_additional_info, iss_rs1, iss_rs2,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_rob_entry, disp_logical_type, disp_opcode,
               disp_additional_info, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_val, disp_rs2_val,
        input  cdb_valid, cdb_tag, cdb_value,
        output disp_ready,
        output iss_valid, iss_rob_entry, iss_logical_type, iss_opcode,
               iss_additional_info, iss_rs1, iss_rs2,
        output occupancy
    );

endinterface

// File: rtl/logical_rs_sched_age_matrix_select.sv
// Age matrix over DEPTH entries; returns a one-hot grant for the oldest eligible entry.
// Latency: grant is combinational from eligible; age state updates at the clock edge.
// Backpressure: none; alloc/free/clear are applied unconditionally.
//   alloc_oh  : entry being written this cycle (becomes youngest)
//   valid_vec : registered valid bits of the station
//   free_oh   : entries leaving this cycle
//   clear     : drop all age relations (flush)
//   eligible  : candidate entries; grant_oh : oldest candidate
module age_matrix_select import logical_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] valid_vec,
    input  logic [DEPTH-1:0] free_oh,
    input  logic             clear,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant_oh
);

    // older[i][j] set means entry i was allocated before entry j.
    // Among valid entries exactly one direction of each pair is set, so the
    // oldest eligible entry is unique.
    logic [DEPTH-1:0] older [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_oh[j]) begin
                        // Everything surviving this edge is older than the newcomer.
                        older[i][j] <= valid_vec[i] & ~free_oh[i];
                    end else if (alloc_oh[i]) begin
                        older[i][j] <= 1'b0;
                    end else if (free_oh[i] || free_oh[j]) begin
                        older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // An eligible entry wins unless some other eligible entry is older than it.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_oh[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (eligible[j] && older[j][i]) begin
                    grant_oh[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/logical_rs_sched.sv
// Reservation station for the logical/shift FU: buffers ops, captures CDB operands, issues oldest ready.
// Latency: dispatch with ready operands at edge N -> registered issue at edge N+1 (2 edges minimum).
// Backpressure: disp_ready low when all entries are valid; issue side never stalls.
//   clk, rst : clock, synchronous active-high reset
//   rs       : logical_rs_sched_if.slave (dispatch, CDB, flush, issue packet, occupancy)
//   Optional macro LOGICAL_RS_PERF_EN adds perf_issued / perf_full_cycles /
//   perf_idle_cycles saturating 32-bit counters as extra output ports.
module logical_rs_sched import logical_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 256,
    parameter int RS_DEPTH = 4,
    parameter int TAG_W    = tag_w(ROB_SIZE),
    parameter int OCC_W    = $clog2(RS_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    logical_rs_sched_if.slave   rs
`ifdef LOGICAL_RS_PERF_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_full_cycles,
    output logic [31:0]         perf_idle_cycles
`endif
);

    // Entry storage
    logic [RS_DEPTH-1:0] ent_valid;
    logic [RS_DEPTH-1:0] ent_rs1_rdy;
    logic [RS_DEPTH-1:0] ent_rs2_rdy;
    logic [TAG_W-1:0]    ent_rs1_tag [RS_DEPTH];
    logic [TAG_W-1:0]    ent_rs2_tag [RS_DEPTH];
    logic [XLEN-1:0]     ent_rs1_val [RS_DEPTH];
    logic [XLEN-1:0]     ent_rs2_val [RS_DEPTH];
    logic [TAG_W-1:0]    ent_rob     [RS_DEPTH];
    op_ctrl_t            ent_ctrl    [RS_DEPTH];

    logic [RS_DEPTH-1:0] alloc_oh;
    logic                alloc_found;
    logic [RS_DEPTH-1:0] eligible;
    logic [RS_DEPTH-1:0] grant_oh;
    logic                any_grant;
    logic                disp_rdy_int;
    logic                disp_fire;

    logic                disp_rs1_rdy_eff;
    logic                disp_rs2_rdy_eff;
    logic [XLEN-1:0]     disp_rs1_val_eff;
    logic [XLEN-1:0]     disp_rs2_val_eff;
    op_ctrl_t            disp_ctrl;

    logic [TAG_W-1:0]    sel_rob;
    op_ctrl_t            sel_ctrl;
    logic [XLEN-1:0]     sel_rs1;
    logic [XLEN-1:0]     sel_rs2;
    logic [OCC_W-1:0]    occ;

    // Readiness looks only at registered valids, so an entry issuing this
    // cycle does not open a slot until the following cycle.
    assign disp_rdy_int  = ~&ent_valid;
    assign rs.disp_ready = disp_rdy_int;
    assign disp_fire     = rs.disp_valid & disp_rdy_int & ~rs.flush;

    // Lowest-index free entry
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!ent_valid[i] && !alloc_found) begin
                alloc_oh[i] = disp_fire;
                alloc_found = 1'b1;
            end
        end
    end

    // Same-cycle CDB bypass into a newly dispatched operand
    always_comb begin
        disp_rs1_rdy_eff = rs.disp_rs1_rdy | (rs.cdb_valid && (rs.cdb_tag == rs.disp_rs1_tag));
        disp_rs2_rdy_eff = rs.disp_rs2_rdy | (rs.cdb_valid && (rs.cdb_tag == rs.disp_rs2_tag));
        disp_rs1_val_eff = rs.disp_rs1_rdy ? rs.disp_rs1_val : rs.cdb_value;
        disp_rs2_val_eff = rs.disp_rs2_rdy ? rs.disp_rs2_val : rs.cdb_value;
        disp_ctrl.logical_type    = rs.disp_logical_type;
        disp_ctrl.opcode          = rs.disp_opcode;
        disp_ctrl.additional_info = rs.disp_additional_info;
    end

    // Eligibility uses registered ready bits only: no wakeup-to-select path.
    assign eligible  = ent_valid & ent_rs1_rdy & ent_rs2_rdy;
    assign any_grant = |grant_oh;

    age_matrix_select #(.DEPTH(RS_DEPTH)) u_age (
        .clk       (clk),
        .rst       (rst),
        .alloc_oh  (alloc_oh),
        .valid_vec (ent_valid),
        .free_oh   (grant_oh),
        .clear     (rs.flush),
        .eligible  (eligible),
        .grant_oh  (grant_oh)
    );

    // One-hot grant mux
    always_comb begin
        sel_rob  = '0;
        sel_ctrl = '0;
        sel_rs1  = '0;
        sel_rs2  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant_oh[i]) begin
                sel_rob  = ent_rob[i];
                sel_ctrl = ent_ctrl[i];
                sel_rs1  = ent_rs1_val[i];
                sel_rs2  = ent_rs2_val[i];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            occ = occ + OCC_W'(ent_valid[i]);
        end
    end
    assign rs.occupancy = occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid              <= '0;
            ent_rs1_rdy            <= '0;
            ent_rs2_rdy            <= '0;
            rs.iss_valid           <= 1'b0;
            rs.iss_rob_entry       <= '0;
            rs.iss_logical_type    <= '0;
            rs.iss_opcode          <= '0;
            rs.iss_additional_info <= 1'b0;
            rs.iss_rs1             <= '0;
            rs.iss_rs2             <= '0;
        end else if (rs.flush) begin
            ent_valid    <= '0;
            rs.iss_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                // Wakeup of waiting operands
                if (ent_valid[i] && rs.cdb_valid) begin
                    if (!ent_rs1_rdy[i] && (ent_rs1_tag[i] == rs.cdb_tag)) begin
                        ent_rs1_rdy[i] <= 1'b1;
                        ent_rs1_val[i] <= rs.cdb_value;
                    end
                    if (!ent_rs2_rdy[i] && (ent_rs2_tag[i] == rs.cdb_tag)) begin
                        ent_rs2_rdy[i] <= 1'b1;
                        ent_rs2_val[i] <= rs.cdb_value;
                    end
                end
                if (grant_oh[i]) begin
                    ent_valid[i] <= 1'b0;
                end
                // alloc_oh only ever targets an invalid entry, so it never
                // collides with the wakeup or free above.
                if (alloc_oh[i]) begin
                    ent_valid[i]   <= 1'b1;
                    ent_rob[i]     <= rs.disp_rob_entry;
                    ent_ctrl[i]    <= disp_ctrl;
                    ent_rs1_rdy[i] <= disp_rs1_rdy_eff;
                    ent_rs2_rdy[i] <= disp_rs2_rdy_eff;
                    ent_rs1_tag[i] <= rs.disp_rs1_tag;
                    ent_rs2_tag[i] <= rs.disp_rs2_tag;
                    ent_rs1_val[i] <= disp_rs1_val_eff;
                    ent_rs2_val[i] <= disp_rs2_val_eff;
                end
            end
            rs.iss_valid <= any_grant;
            if (any_grant) begin
                rs.iss_rob_entry       <= sel_rob;
                rs.iss_logical_type    <= sel_ctrl.logical_type;
                rs.iss_opcode          <= sel_ctrl.opcode;
                rs.iss_additional_info <= sel_ctrl.additional_info;
                rs.iss_rs1             <= sel_rs1;
                rs.iss_rs2             <= sel_rs2;
            end
        end
    end

`ifdef LOGICAL_RS_PERF_EN
    // Saturating event counters; survive flush, cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued      <= '0;
            perf_full_cycles <= '0;
            perf_idle_cycles <= '0;
        end else begin
            if (rs.iss_valid && (perf_issued != 32'hFFFF_FFFF)) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (rs.disp_valid && !disp_rdy_int && (perf_full_cycles != 32'hFFFF_FFFF)) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if ((|ent_valid) && !(|eligible) && (perf_idle_cycles != 32'hFFFF_FFFF)) begin
                perf_idle_cycles <= perf_idle_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_logical_rs_sched.sv
// Self-checking bench for logical_rs_sched: directed scenarios plus random traffic
// compared every cycle against an entry-list model ordered by dispatch sequence number.
module tb_logical_rs_sched;
    import logical_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int D     = 4;
    localparam int OCC_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logical_rs_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W), .OCC_W(OCC_W)) bus ();

    logical_rs_sched #(.XLEN(XLEN), .ROB_SIZE(256), .RS_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit              v;
        int unsigned     seq;
        bit              r1;
        bit              r2;
        logic [7:0]      t1;
        logic [7:0]      t2;
        logic [31:0]     v1;
        logic [31:0]     v2;
        logic [7:0]      rob;
        logic [2:0]      lt;
        logic [4:0]      opc;
        logic            ai;
    } ment_t;

    ment_t       m [D];
    int unsigned seq_ctr;
    logic        m_iss_valid;
    logic [7:0]  m_iss_rob;
    logic [2:0]  m_iss_lt;
    logic [4:0]  m_iss_opc;
    logic        m_iss_ai;
    logic [31:0] m_iss_rs1;
    logic [31:0] m_iss_rs2;

    initial begin : model_proc
        int best;
        int slot;
        int nvalid;
        forever begin
            @(posedge clk);
            if (rst) begin
                foreach (m[i]) m[i].v = 1'b0;
                seq_ctr     = 0;
                m_iss_valid = 1'b0;
                m_iss_rob   = '0;
                m_iss_lt    = '0;
                m_iss_opc   = '0;
                m_iss_ai    = 1'b0;
                m_iss_rs1   = '0;
                m_iss_rs2   = '0;
            end else if (bus.flush) begin
                foreach (m[i]) m[i].v = 1'b0;
                m_iss_valid = 1'b0;
            end else begin
                // Decisions use state as it stood before this edge.
                best   = -1;
                slot   = -1;
                nvalid = 0;
                foreach (m[i]) begin
                    if (m[i].v) nvalid++;
                    if (m[i].v && m[i].r1 && m[i].r2 && (best < 0 || m[i].seq < m[best].seq))
                        best = i;
                    if (!m[i].v && slot < 0) slot = i;
                end
                foreach (m[i]) begin
                    if (m[i].v && bus.cdb_valid) begin
                        if (!m[i].r1 && m[i].t1 == bus.cdb_tag) begin m[i].r1 = 1'b1; m[i].v1 = bus.cdb_value; end
                        if (!m[i].r2 && m[i].t2 == bus.cdb_tag) begin m[i].r2 = 1'b1; m[i].v2 = bus.cdb_value; end
                    end
                end
                m_iss_valid = (best >= 0);
                if (best >= 0) begin
                    m_iss_rob = m[best].rob;
                    m_iss_lt  = m[best].lt;
                    m_iss_opc = m[best].opc;
                    m_iss_ai  = m[best].ai;
                    m_iss_rs1 = m[best].v1;
                    m_iss_rs2 = m[best].v2;
                    m[best].v = 1'b0;
                end
                if (bus.disp_valid && nvalid < D) begin
                    m[slot].v   = 1'b1;
                    m[slot].seq = seq_ctr;
                    seq_ctr++;
                    m[slot].rob = bus.disp_rob_entry;
                    m[slot].lt  = bus.disp_logical_type;
                    m[slot].opc = bus.disp_opcode;
                    m[slot].ai  = bus.disp_additional_info;
                    m[slot].t1  = bus.disp_rs1_tag;
                    m[slot].t2  = bus.disp_rs2_tag;
                    m[slot].r1  = bus.disp_rs1_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_rs1_tag);
                    m[slot].r2  = bus.disp_rs2_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_rs2_tag);
                    m[slot].v1  = bus.disp_rs1_rdy ? bus.disp_rs1_val : bus.cdb_value;
                    m[slot].v2  = bus.disp_rs2_rdy ? bus.disp_rs2_val : bus.cdb_value;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : cmp_proc
        int cnt;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cnt = 0;
                foreach (m[i]) if (m[i].v) cnt++;
                chk("occupancy",  64'(bus.occupancy), 64'(cnt));
                chk("disp_ready", 64'(bus.disp_ready), 64'(cnt < D));
                chk("iss_valid",  64'(bus.iss_valid), 64'(m_iss_valid));
                chk("iss_rob",    64'(bus.iss_rob_entry), 64'(m_iss_rob));
                chk("iss_lt",     64'(bus.iss_logical_type), 64'(m_iss_lt));
                chk("iss_opc",    64'(bus.iss_opcode), 64'(m_iss_opc));
                chk("iss_ai",     64'(bus.iss_additional_info), 64'(m_iss_ai));
                chk("iss_rs1",    64'(bus.iss_rs1), 64'(m_iss_rs1));
                chk("iss_rs2",    64'(bus.iss_rs2), 64'(m_iss_rs2));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.flush                = 1'b0;
        bus.disp_valid           = 1'b0;
        bus.disp_rob_entry       = '0;
        bus.disp_logical_type    = '0;
        bus.disp_opcode          = '0;
        bus.disp_additional_info = 1'b0;
        bus.disp_rs1_rdy         = 1'b0;
        bus.disp_rs2_rdy         = 1'b0;
        bus.disp_rs1_tag         = '0;
        bus.disp_rs2_tag         = '0;
        bus.disp_rs1_val         = '0;
        bus.disp_rs2_val         = '0;
        bus.cdb_valid            = 1'b0;
        bus.cdb_tag              = '0;
        bus.cdb_value            = '0;
    endtask

    task automatic disp(input logic [7:0] rob, input logic [2:0] lt,
                        input logic r1, input logic [7:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [7:0] t2, input logic [31:0] v2);
        bus.disp_valid        = 1'b1;
        bus.disp_rob_entry    = rob;
        bus.disp_logical_type = lt;
        bus.disp_opcode       = OPC_LOGICAL;
        bus.disp_rs1_rdy      = r1;
        bus.disp_rs1_tag      = t1;
        bus.disp_rs1_val      = v1;
        bus.disp_rs2_rdy      = r2;
        bus.disp_rs2_tag      = t2;
        bus.disp_rs2_val      = v2;
    endtask

    task automatic cdb(input logic [7:0] tag, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = val;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_occ",   64'(bus.occupancy), 64'd0);
        chk("rst_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_iss_v", 64'(bus.iss_valid), 64'd0);
        chk("rst_rs1",   64'(bus.iss_rs1), 64'd0);
        rst = 1'b0;

        // Both operands ready: XOR
        disp(8'd1, LT_XOR, 1'b1, 8'd0, 32'hF0F0_0000, 1'b1, 8'd0, 32'h0FF0_0000);
        cyc(); idle();
        chk("t1_occ1", 64'(bus.occupancy), 64'd1);
        chk("t1_nov",  64'(bus.iss_valid), 64'd0);
        cyc();
        chk("t1_v",    64'(bus.iss_valid), 64'd1);
        chk("t1_rob",  64'(bus.iss_rob_entry), 64'd1);
        chk("t1_lt",   64'(bus.iss_logical_type), 64'(3'b100));
        chk("t1_rs1",  64'(bus.iss_rs1), 64'hF0F0_0000);
        chk("t1_rs2",  64'(bus.iss_rs2), 64'h0FF0_0000);
        chk("t1_occ0", 64'(bus.occupancy), 64'd0);

        // Younger ready op overtakes older waiting op
        disp(8'd10, LT_OR, 1'b1, 8'd0, 32'h11, 1'b0, 8'd7, 32'h0);
        cyc();
        disp(8'd11, LT_AND, 1'b1, 8'd0, 32'h22, 1'b1, 8'd0, 32'h33);
        cyc(); idle();
        cyc();
        chk("t2_b_v",   64'(bus.iss_valid), 64'd1);
        chk("t2_b_rob", 64'(bus.iss_rob_entry), 64'd11);
        cyc();
        cdb(8'd7, 32'h5);
        cyc(); idle();
        chk("t2_wait",  64'(bus.iss_valid), 64'd0);
        cyc();
        chk("t2_a_v",   64'(bus.iss_valid), 64'd1);
        chk("t2_a_rob", 64'(bus.iss_rob_entry), 64'd10);
        chk("t2_a_rs2", 64'(bus.iss_rs2), 64'h5);
        chk("t2_a_rs1", 64'(bus.iss_rs1), 64'h11);

        // Dispatch-cycle bypass from CDB
        disp(8'd20, LT_AND, 1'b0, 8'd3, 32'h0, 1'b1, 8'd0, 32'h77);
        cdb(8'd3, 32'hABCD);
        cyc(); idle();
        chk("t3_occ", 64'(bus.occupancy), 64'd1);
        cyc();
        chk("t3_v",   64'(bus.iss_valid), 64'd1);
        chk("t3_rob", 64'(bus.iss_rob_entry), 64'd20);
        chk("t3_rs1", 64'(bus.iss_rs1), 64'hABCD);
        chk("t3_rs2", 64'(bus.iss_rs2), 64'h77);

        // Fill, reject a 5th, wake entry 2
        for (int k = 0; k < 4; k++) begin
            disp(8'(30 + k), LT_SLL, 1'b0, 8'(40 + k), 32'h0, 1'b1, 8'd0, 32'(k));
            cyc();
        end
        idle();
        chk("t4_full_rdy", 64'(bus.disp_ready), 64'd0);
        chk("t4_full_occ", 64'(bus.occupancy), 64'd4);
        disp(8'd34, LT_XOR, 1'b1, 8'd0, 32'h1, 1'b1, 8'd0, 32'h2);
        cyc(); idle();
        chk("t4_rej_occ", 64'(bus.occupancy), 64'd4);
        cyc();
        chk("t4_rej_v",   64'(bus.iss_valid), 64'd0);
        cdb(8'd42, 32'h42);
        cyc(); idle();
        chk("t4_woke_rdy", 64'(bus.disp_ready), 64'd0);
        cyc();
        chk("t4_iss_v",   64'(bus.iss_valid), 64'd1);
        chk("t4_iss_rob", 64'(bus.iss_rob_entry), 64'd32);
        chk("t4_iss_rs1", 64'(bus.iss_rs1), 64'h42);
        chk("t4_rdy_up",  64'(bus.disp_ready), 64'd1);
        chk("t4_occ3",    64'(bus.occupancy), 64'd3);

        // Flush with 3 valid entries and a pending dispatch
        disp(8'd50, LT_OR, 1'b1, 8'd0, 32'h9, 1'b1, 8'd0, 32'h9);
        bus.flush = 1'b1;
        cyc(); idle();
        chk("t6_occ", 64'(bus.occupancy), 64'd0);
        chk("t6_v",   64'(bus.iss_valid), 64'd0);
        cdb(8'd40, 32'hDEAD);
        cyc(); idle();
        cyc();
        chk("t6_late_v",   64'(bus.iss_valid), 64'd0);
        chk("t6_late_occ", 64'(bus.occupancy), 64'd0);

        // Two entries woken by one broadcast issue in age order
        disp(8'd60, LT_XOR, 1'b0, 8'd50, 32'h0, 1'b1, 8'd0, 32'h1);
        cyc();
        disp(8'd61, LT_OR, 1'b0, 8'd50, 32'h0, 1'b1, 8'd0, 32'h2);
        cyc(); idle();
        cdb(8'd50, 32'h5050);
        cyc(); idle();
        chk("t5_none", 64'(bus.iss_valid), 64'd0);
        cyc();
        chk("t5_a_rob", 64'(bus.iss_rob_entry), 64'd60);
        chk("t5_a_rs1", 64'(bus.iss_rs1), 64'h5050);
        cyc();
        chk("t5_b_v",   64'(bus.iss_valid), 64'd1);
        chk("t5_b_rob", 64'(bus.iss_rob_entry), 64'd61);
        chk("t5_b_rs2", 64'(bus.iss_rs2), 64'h2);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 99) < 55) begin
                disp(8'($urandom), 3'($urandom),
                     ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 7)), $urandom,
                     ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 7)), $urandom);
                bus.disp_opcode          = 5'($urandom);
                bus.disp_additional_info = 1'($urandom);
            end
            if ($urandom_range(0, 99) < 45) cdb(8'($urandom_range(0, 7)), $urandom);
            bus.flush = ($urandom_range(0, 99) < 2);
            cyc();
        end
        idle();
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
